// File: rtl/lzd_norm_ctrl.sv
// Normalization-stage sequencer: captures the add/sub result, runs the shared
// registered LZD through load/result, then shifts mantissa and adjusts exponent.
module lzd_norm_ctrl #(
    parameter int SWR     = 26,
    parameter int EWR     = 5,
    parameter int W_Exp   = 8,
    parameter int LZD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [SWR-1:0]   Add_subt_result_i,
    input  logic [W_Exp-1:0] exp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             lzd_load_o,
    output logic [SWR-1:0]   lzd_result_o,
    input  logic [EWR-1:0]   lzd_shift_i,
    output logic [SWR-1:0]   norm_mant_o,
    output logic [W_Exp-1:0] norm_exp_o,
    output logic             zero_o,
    output logic             underflow_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int            CW       = (LZD_LAT > 1) ? $clog2(LZD_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(LZD_LAT - 1);

    logic [2:0]       r_state;
    logic [SWR-1:0]   r_mant;
    logic [W_Exp-1:0] r_exp;
    logic [EWR-1:0]   r_shift;
    logic [CW-1:0]    r_wait_cnt;
    logic [SWR-1:0]   r_norm_mant;
    logic [W_Exp-1:0] r_norm_exp;
    logic             r_zero;
    logic             r_underflow;

    logic             w_idle_or_done;
    logic             w_too_far;
    logic [W_Exp-1:0] w_shift_ext;

    // Handshake: a request is taken on any edge where start_i=1 and the FSM is
    // in IDLE or DONE; there is no ready output, busy_o=1 means start_i is dropped.
    // Toward the LZD, lzd_load_o is a one-cycle strobe with lzd_result_o stable
    // until the count is sampled LZD_LAT cycles later.
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_too_far      = {{(32-EWR){1'b0}}, r_shift} >= 32'(SWR);
    assign w_shift_ext    = W_Exp'(r_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_shift     <= '0;
            r_wait_cnt  <= '0;
            r_norm_mant <= '0;
            r_norm_exp  <= '0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_mant      <= Add_subt_result_i;
                        r_exp       <= exp_i;
                        r_underflow <= 1'b0;
                        if (Add_subt_result_i == '0) begin
                            // Zero result skips the LZD entirely.
                            r_norm_mant <= '0;
                            r_norm_exp  <= '0;
                            r_zero      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_zero  <= 1'b0;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == LAT_LAST) begin
                        r_shift <= lzd_shift_i;
                        r_state <= S_SHIFT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    r_norm_mant <= w_too_far ? '0 : (r_mant << r_shift);
                    r_zero      <= w_too_far;
                    // Underflow clamps the exponent but keeps the full mantissa shift.
                    if (w_shift_ext > r_exp) begin
                        r_norm_exp  <= '0;
                        r_underflow <= 1'b1;
                    end else begin
                        r_norm_exp  <= r_exp - w_shift_ext;
                        r_underflow <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_SHIFT);
    assign done_o       = (r_state == S_DONE);
    assign lzd_load_o   = (r_state == S_LOAD);
    assign lzd_result_o = r_mant;
    assign norm_mant_o  = r_norm_mant;
    assign norm_exp_o   = r_norm_exp;
    assign zero_o       = r_zero;
    assign underflow_o  = r_underflow;
    assign state_o      = r_state;

endmodule

// File: tb/tb_lzd_norm_ctrl.sv
// Self-checking bench for lzd_norm_ctrl with a behavioural 1-cycle registered LZD.
module tb_lzd_norm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [25:0] mant_in = '0;
    logic [7:0]  exp_in = '0;
    logic        busy_o, done_o, lzd_load_o, zero_o, underflow_o;
    logic [25:0] lzd_result_o, norm_mant_o;
    logic [7:0]  norm_exp_o;
    logic [4:0]  lzd_shift;
    logic [2:0]  state_o;

    int tests = 0;
    int fails = 0;
    logic [35:0] exp_q[$];

    lzd_norm_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start),
        .Add_subt_result_i(mant_in), .exp_i(exp_in),
        .busy_o(busy_o), .done_o(done_o), .lzd_load_o(lzd_load_o),
        .lzd_result_o(lzd_result_o), .lzd_shift_i(lzd_shift),
        .norm_mant_o(norm_mant_o), .norm_exp_o(norm_exp_o),
        .zero_o(zero_o), .underflow_o(underflow_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int clz(input logic [25:0] v);
        for (int i = 25; i >= 0; i--) if (v[i]) return 25 - i;
        return 26;
    endfunction

    // Behavioural LZD: count appears one cycle after the load strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) lzd_shift <= '0;
        else if (lzd_load_o) lzd_shift <= 5'(clz(lzd_result_o));
    end

    // Reference result {mant, exp, zero, underflow} from the normalization rules.
    function automatic logic [35:0] ref_norm(input logic [25:0] m, input logic [7:0] e);
        int n;
        if (m == 26'd0) return {26'd0, 8'd0, 1'b1, 1'b0};
        n = clz(m);
        if (n > int'(e)) return {26'(m << n), 8'd0, 1'b0, 1'b1};
        return {26'(m << n), 8'(int'(e) - n), 1'b0, 1'b0};
    endfunction

    // Called at a negedge; returns the cycle index (edge 0 = accept) where done_o is seen.
    task automatic do_op(input logic [25:0] m, input logic [7:0] e,
                         output int lat, output int loads, output logic [25:0] res_at_load);
        start = 1'b1; mant_in = m; exp_in = e;
        @(posedge clk); #1;
        start = 1'b0; mant_in = 26'($urandom); exp_in = 8'($urandom);
        lat = 0; loads = 0; res_at_load = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lzd_load_o) begin loads++; res_at_load = lzd_result_o; end
            if (done_o) begin lat = c; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({busy_o, done_o, lzd_load_o, zero_o, underflow_o, lzd_result_o, norm_mant_o, norm_exp_o, state_o} !== '0) begin
            fails++;
            $display("FAIL reset_in: got busy=%b done=%b load=%b z=%b uf=%b res=%h mant=%h exp=%h st=%0d required all 0",
                     busy_o, done_o, lzd_load_o, zero_o, underflow_o, lzd_result_o, norm_mant_o, norm_exp_o, state_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || state_o !== 3'd0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b done=%b st=%0d required 0 0 0", busy_o, done_o, state_o);
        end
    endtask

    task automatic test_normalize;
        logic [25:0] m_tab[2]  = '{26'h0000100, 26'h2000001};
        logic [7:0]  e_tab[2]  = '{8'd100, 8'd127};
        logic [25:0] em_tab[2] = '{26'h2000000, 26'h2000001};
        logic [7:0]  ee_tab[2] = '{8'd83, 8'd127};
        int lat, loads;
        logic [25:0] rl;
        for (int i = 0; i < 2; i++) begin
            do_op(m_tab[i], e_tab[i], lat, loads, rl);
            tests++;
            if (lat !== 4) begin fails++; $display("FAIL norm%0d_latency: got %0d required 4", i, lat); end
            tests++;
            if (loads !== 1) begin fails++; $display("FAIL norm%0d_loads: got %0d required 1", i, loads); end
            tests++;
            if (rl !== m_tab[i]) begin fails++; $display("FAIL norm%0d_lzd_result: got %h required %h", i, rl, m_tab[i]); end
            tests++;
            if (norm_mant_o !== em_tab[i]) begin fails++; $display("FAIL norm%0d_mant: got %h required %h", i, norm_mant_o, em_tab[i]); end
            tests++;
            if (norm_exp_o !== ee_tab[i]) begin fails++; $display("FAIL norm%0d_exp: got %0d required %0d", i, norm_exp_o, ee_tab[i]); end
            tests++;
            if (zero_o !== 1'b0 || underflow_o !== 1'b0) begin
                fails++; $display("FAIL norm%0d_flags: got z=%b uf=%b required 0 0", i, zero_o, underflow_o);
            end
        end
    endtask

    task automatic test_zero;
        int lat, loads;
        logic [25:0] rl;
        do_op(26'd0, 8'd50, lat, loads, rl);
        tests++;
        if (lat !== 1) begin fails++; $display("FAIL zero_latency: got %0d required 1", lat); end
        tests++;
        if (loads !== 0) begin fails++; $display("FAIL zero_loads: got %0d required 0", loads); end
        tests++;
        if ({norm_mant_o, norm_exp_o, zero_o, underflow_o} !== {26'd0, 8'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL zero_result: got mant=%h exp=%0d z=%b uf=%b required 0 0 1 0", norm_mant_o, norm_exp_o, zero_o, underflow_o);
        end
    endtask

    task automatic test_underflow;
        int lat, loads;
        logic [25:0] rl;
        do_op(26'h0000001, 8'd10, lat, loads, rl);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL uf_latency: got %0d required 4", lat); end
        tests++;
        if ({norm_mant_o, norm_exp_o, zero_o, underflow_o} !== {26'h2000000, 8'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL uf_result: got mant=%h exp=%0d z=%b uf=%b required 2000000 0 0 1", norm_mant_o, norm_exp_o, zero_o, underflow_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] pat[2] = '{16'h0FFF, 16'h000D};
        logic [19:0] got, want;
        int free_at, loads;
        for (int p = 0; p < 2; p++) begin
            repeat (3) @(negedge clk);
            want = '0; free_at = 0;
            for (int c = 0; c < 16; c++)
                if (pat[p][c] && c >= free_at) begin want[c+4] = 1'b1; free_at = c + 4; end
            got = '0; loads = 0;
            mant_in = 26'h0000100; exp_in = 8'd100;
            for (int c = 0; c < 19; c++) begin
                start = (c < 16) ? pat[p][c] : 1'b0;
                @(posedge clk);
                @(negedge clk);
                got[c+1] = done_o;
                if (lzd_load_o) loads++;
            end
            start = 1'b0;
            tests++;
            if (got !== want) begin fails++; $display("FAIL b2b%0d_done_cycles: got %b required %b", p, got, want); end
            tests++;
            if (loads !== $countones(want)) begin fails++; $display("FAIL b2b%0d_loads: got %0d required %0d", p, loads, $countones(want)); end
            tests++;
            if (norm_mant_o !== 26'h2000000 || norm_exp_o !== 8'd83) begin
                fails++; $display("FAIL b2b%0d_result: got mant=%h exp=%0d required 2000000 83", p, norm_mant_o, norm_exp_o);
            end
        end
    endtask

    task automatic test_reset_abort;
        int lat, loads, stray;
        logic [25:0] rl;
        for (int k = 1; k <= 2; k++) begin
            repeat (2) @(negedge clk);
            start = 1'b1; mant_in = 26'h0000100; exp_in = 8'd100;
            @(posedge clk); #1 start = 1'b0;
            for (int c = 1; c < k; c++) @(posedge clk);
            @(negedge clk);
            tests++;
            if (busy_o !== 1'b1 || lzd_load_o !== (k == 1)) begin
                fails++; $display("FAIL abort%0d_pre: got busy=%b load=%b required 1 %b", k, busy_o, lzd_load_o, k == 1);
            end
            #2 rst = 1'b1;
            #1;
            tests++;
            if ({busy_o, done_o, lzd_load_o, zero_o, underflow_o, lzd_result_o, norm_mant_o, norm_exp_o, state_o} !== '0) begin
                fails++;
                $display("FAIL abort%0d_async: got busy=%b done=%b load=%b mant=%h exp=%h st=%0d required all 0",
                         k, busy_o, done_o, lzd_load_o, norm_mant_o, norm_exp_o, state_o);
            end
            @(negedge clk);
            rst = 1'b0;
        end
        stray = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); if (done_o || busy_o) stray++; end
        tests++;
        if (stray !== 0) begin fails++; $display("FAIL abort_stray: got %0d active cycles required 0", stray); end
        do_op(26'h0000100, 8'd100, lat, loads, rl);
        tests++;
        if (lat !== 4 || norm_mant_o !== 26'h2000000 || norm_exp_o !== 8'd83) begin
            fails++; $display("FAIL abort_recover: got lat=%0d mant=%h exp=%0d required 4 2000000 83", lat, norm_mant_o, norm_exp_o);
        end
    endtask

    task automatic test_random;
        int lat, loads, want_lat;
        logic [25:0] m, rl;
        logic [7:0]  e;
        logic [35:0] want;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            m = ($urandom_range(0, 7) == 0) ? 26'd0 : 26'($urandom) >> $urandom_range(0, 25);
            e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            exp_q.push_back(ref_norm(m, e));
            want_lat = (m == 26'd0) ? 1 : 4;
            do_op(m, e, lat, loads, rl);
            tests++;
            if (lat !== want_lat) begin fails++; $display("FAIL rand%0d_latency: got %0d required %0d (m=%h)", n, lat, want_lat, m); end
            want = exp_q.pop_front();
            tests++;
            if ({norm_mant_o, norm_exp_o, zero_o, underflow_o} !== want) begin
                fails++;
                $display("FAIL rand%0d_result: got %h required %h (m=%h e=%0d)", n,
                         {norm_mant_o, norm_exp_o, zero_o, underflow_o}, want, m, e);
            end
        end
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL rand_queue: got %0d left required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_zero();
        test_underflow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
